peripheral_spi_slave: RTL

J1-bus SPI slave peripheral: the responder end of the SPI link that peripheral_SD drives as master. It lets a second j1soc, or a bench master, exchange bytes with this J1 over sclk/mosi/miso/ss. It sits behind the j1soc chip-select decoder like any other peripheral, using the same d_in/cs/addr/rd/wr/d_out bus. SPI mode 0, 8-bit frames, MSB first, full duplex.

---
 rtl/peripheral_spi_slave_pkg.sv | 25 ++
 rtl/peripheral_spi_slave_sync_edge.sv | 32 +++
 rtl/peripheral_spi_slave.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_spi_slave_pkg.sv
// Shared types for the J1-bus SPI slave peripheral.
// Frame states, the STATUS register layout and the underrun fill byte.
package peripheral_spi_slave_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

    typedef struct packed {
        logic underrun;
        logic busy;
        logic overrun;
        logic tx_empty;
        logic rx_valid;
    } spi_status_t;

    localparam logic [7:0] TX_FILL  = 8'hFF;
    localparam logic [2:0] LAST_BIT = 3'd7;

    function automatic logic [15:0] status_word(input spi_status_t st);
        return {11'b0, st};
    endfunction

endpackage

// File: rtl/peripheral_spi_slave_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses for an async SPI line.
// The reset value lets each line start in its own idle level.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{rst_val}};
            dly_q  <= rst_val;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~dly_q;
    assign fall = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/peripheral_spi_slave.sv
// SPI mode-0 slave on the J1 peripheral bus: 8-bit MSB-first full duplex.
// TXDATA/RXDATA/STATUS registers; all SPI lines sampled through synchronizers.
module peripheral_spi_slave
    import peripheral_spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        ss,
    output logic        miso,
    output logic        miso_oe
);

    localparam logic [3:0] TXDATA = 4'h0;
    localparam logic [3:0] RXDATA = 4'h2;
    localparam logic [3:0] STATUS = 4'h4;

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s;
    logic [SYNC_STAGES-1:0] mosi_q;

    spi_state_e state_q, state_d;
    logic frame_start, frame_abort;
    logic bit_rise, bit_fall;

    logic [2:0] bit_cnt_q;
    logic       load_pending_q;
    logic [7:0] shift_tx_q, shift_rx_q;
    logic [7:0] tx_hold_q, rx_data_q;
    logic       tx_empty_q, rx_valid_q;
    logic       overrun_q, underrun_q;

    logic wr_tx, rd_rx, wr_st, rd_st;
    logic load_now, shift_now, byte_done;
    logic [7:0] rx_byte, load_val;
    spi_status_t status;
    logic unused_sig;

    spi_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sclk_sync (
        .clk     (clk),
        .reset   (reset),
        .rst_val (1'b0),
        .din     (sclk),
        .dout    (sclk_s),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_ss_sync (
        .clk     (clk),
        .reset   (reset),
        .rst_val (1'b1),
        .din     (ss),
        .dout    (ss_s),
        .rise    (ss_rise),
        .fall    (ss_fall)
    );

    // mosi only needs a level, aligned with the sclk synchronizer delay
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (ss_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (ss_rise) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        frame_abort = 1'b0;
        bit_rise    = 1'b0;
        bit_fall    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                frame_start = ss_fall;
            end
            ST_SHIFT: begin
                frame_abort = ss_rise;
                bit_rise    = sclk_rise & ~ss_rise;
                bit_fall    = sclk_fall & ~ss_rise;
            end
            default: begin
                frame_start = 1'b0;
            end
        endcase
    end

    assign wr_tx = cs & wr & (addr == TXDATA);
    assign rd_rx = cs & rd & (addr == RXDATA);
    assign wr_st = cs & wr & (addr == STATUS);
    assign rd_st = cs & rd & (addr == STATUS);

    assign load_now  = frame_start | (bit_fall & load_pending_q);
    assign shift_now = bit_fall & ~load_pending_q;
    assign byte_done = bit_rise & (bit_cnt_q == LAST_BIT);
    assign rx_byte   = {shift_rx_q[6:0], mosi_s};
    assign load_val  = tx_empty_q ? TX_FILL : tx_hold_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q      <= '0;
            load_pending_q <= 1'b0;
            shift_rx_q     <= '0;
        end else if (frame_start || frame_abort) begin
            bit_cnt_q      <= '0;
            load_pending_q <= 1'b0;
        end else begin
            if (bit_rise) begin
                shift_rx_q <= rx_byte;
                bit_cnt_q  <= bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
                load_pending_q <= 1'b1;
            end else if (bit_fall) begin
                load_pending_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_tx_q <= '0;
        end else if (load_now) begin
            shift_tx_q <= load_val;
        end else if (shift_now) begin
            shift_tx_q <= {shift_tx_q[6:0], 1'b0};
        end
    end

    // a bus write beats a same-cycle load: the load already took the old byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_hold_q  <= '0;
            tx_empty_q <= 1'b1;
        end else if (wr_tx) begin
            tx_hold_q  <= d_in[7:0];
            tx_empty_q <= 1'b0;
        end else if (load_now) begin
            tx_empty_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (byte_done) begin
            rx_data_q  <= rx_byte;
            rx_valid_q <= 1'b1;
        end else if (rd_rx) begin
            rx_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (byte_done && rx_valid_q && !rd_rx) begin
                overrun_q <= 1'b1;
            end else if (wr_st && d_in[2]) begin
                overrun_q <= 1'b0;
            end
            if (load_now && tx_empty_q) begin
                underrun_q <= 1'b1;
            end else if (wr_st && d_in[4]) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign status = {underrun_q, ~ss_s, overrun_q, tx_empty_q, rx_valid_q};

    always_comb begin
        d_out = '0;
        unique case (1'b1)
            rd_rx:   d_out = {8'h00, rx_data_q};
            rd_st:   d_out = status_word(status);
            default: d_out = '0;
        endcase
    end

    assign miso    = shift_tx_q[7];
    assign miso_oe = ~ss_s;

    assign unused_sig = ^{sclk_s, d_in[15:8]};

endmodule
